outport_out_interface_ctrl: RTL

OUTPORT_OUT_INTERFACE_CTRL -- requirements
Module: outport_out_interface_ctrl

---
 rtl/outport_out_interface_ctrl_pkg.sv | 30 +++
 rtl/outport_out_interface_ctrl_if.sv | 39 +++
 rtl/credit_counter.sv | 41 ++++
 rtl/outport_out_interface_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/outport_out_interface_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : outport_out_interface_ctrl_pkg
// Brief   : Shared router definitions: output-port FSM encodings, credit
//           defaults and packet-length helper.
// Revision: 1.0 - initial release
// ============================================================================
package outport_out_interface_ctrl_pkg;

  // Width of the credit counter and of the packet-length fields.
  localparam int CREDIT_W        = 4;
  localparam int LEN_W           = 4;
  // Downstream input-buffer depth used when an instance does not override it.
  localparam int CREDITS_DEFAULT = 4;

  // Output-port FSM encodings; the input-port side decodes the same values.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_SEND = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // A zero-length packet still carries one flit (header-only packet).
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] n);
    return (n == '0) ? LEN_W'(1) : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/outport_out_interface_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : outport_out_interface_ctrl_if
// Brief   : Crossbar/link bundle of the output-port controller. The master
//           modport is the controller; the slave modport is its environment
//           (crossbar, arbiter and downstream input port).
// Revision: 1.0 - initial release
// ============================================================================
interface outport_out_interface_ctrl_if
  import outport_out_interface_ctrl_pkg::*;
#(
  parameter int FLIT_W = 16
) ();

  logic              pkt_valid;
  logic [LEN_W-1:0]  num_flits;
  logic [FLIT_W-1:0] flit_in;
  logic              flit_in_valid;
  logic              flit_in_ready;
  logic              req;
  logic              ack;
  logic              credit_in;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_out_valid;
  state_t            state;
  logic              done;

  modport master (
    input  pkt_valid, num_flits, flit_in, flit_in_valid, ack, credit_in,
    output flit_in_ready, req, flit_out, flit_out_valid, state, done
  );

  modport slave (
    output pkt_valid, num_flits, flit_in, flit_in_valid, ack, credit_in,
    input  flit_in_ready, req, flit_out, flit_out_valid, state, done
  );

endinterface
`default_nettype wire

// File: rtl/credit_counter.sv
`default_nettype none
// ============================================================================
// Module  : credit_counter
// Brief   : Saturating downstream-credit counter. Starts full, counts down on
//           each flit sent and up on each returned credit; a simultaneous
//           send and return leaves the count unchanged.
// Revision: 1.0 - initial release
// ============================================================================
module credit_counter
  import outport_out_interface_ctrl_pkg::*;
#(
  parameter int CREDITS = CREDITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                dec,
  output logic [CREDIT_W-1:0] count,
  output logic                nonzero
);

  localparam logic [CREDIT_W-1:0] c_max = CREDIT_W'(CREDITS);

  logic [CREDIT_W-1:0] r_count;

  // Credit bookkeeping: saturate at the buffer depth, never wrap below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= c_max;
    end else if (inc && !dec) begin
      if (r_count != c_max) r_count <= r_count + CREDIT_W'(1);
    end else if (dec && !inc) begin
      if (r_count != '0) r_count <= r_count - CREDIT_W'(1);
    end
  end

  assign count   = r_count;
  assign nonzero = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/outport_out_interface_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : outport_out_interface_ctrl
// Brief   : Router output-port controller. Handshakes with the downstream
//           input port, then streams one packet from the crossbar onto the
//           link under credit-based flow control.
// Revision: 1.0 - initial release
// ============================================================================
module outport_out_interface_ctrl
  import outport_out_interface_ctrl_pkg::*;
#(
  parameter int FLIT_W  = 16,
  parameter int CREDITS = CREDITS_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rs,
  outport_out_interface_ctrl_if.master  bus
);

  state_t              r_state;
  state_t              w_next;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [FLIT_W-1:0]   r_flit_out;
  logic                r_flit_out_valid;
  logic                w_req;
  logic                w_ready;
  logic                w_xfer;
  logic                w_last;
  logic                w_nonzero;
  logic [CREDIT_W-1:0] w_credit_count;

  // A flit moves only while sending and the downstream buffer has room.
  assign w_xfer = (r_state == ST_SEND) && bus.flit_in_valid && w_nonzero;
  assign w_last = (r_cnt == (r_len - LEN_W'(1)));

  credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit_counter (
    .clk     (clk),
    .rst     (rs),
    .inc     (bus.credit_in),
    .dec     (w_xfer),
    .count   (w_credit_count),
    .nonzero (w_nonzero)
  );

  // Next-state decode and per-state handshake outputs.
  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.pkt_valid) w_next = ST_REQ;
      end
      ST_REQ: begin
        w_req = 1'b1;
        if (bus.ack) w_next = ST_SEND;
      end
      ST_SEND: begin
        w_ready = w_nonzero;
        if (w_xfer && w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, packet length, flit count and link output registers.
  always_ff @(posedge clk) begin
    if (rs) begin
      r_state          <= ST_IDLE;
      r_len            <= LEN_W'(1);
      r_cnt            <= '0;
      r_flit_out       <= '0;
      r_flit_out_valid <= 1'b0;
    end else begin
      r_state          <= w_next;
      r_flit_out_valid <= w_xfer;
      if (w_xfer) r_flit_out <= bus.flit_in;
      if ((r_state == ST_IDLE) && bus.pkt_valid) r_len <= eff_len(bus.num_flits);
      if ((r_state == ST_REQ) && bus.ack) begin
        r_cnt <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
    end
  end

  assign bus.req            = w_req;
  assign bus.flit_in_ready  = w_ready;
  assign bus.flit_out       = r_flit_out;
  assign bus.flit_out_valid = r_flit_out_valid;
  assign bus.state          = r_state;
  assign bus.done           = (r_state == ST_DONE);

endmodule
`default_nettype wire
